// File: rtl/fp_pkg.sv
// Shared types and constant-pattern helpers for the parametrised FP add/sub unit.
// Latency: none, declarations only.
// Backpressure: not applicable.
package fp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        ALIGN,
        ADD,
        NORM,
        ROUND,
        DONE
    } fp_state_t;

    localparam int FP_MAX_W = 64;
    typedef logic [FP_MAX_W-1:0] fp_word_t;

    function automatic int fp_word_w(input int exp_w, input int man_w);
        return 1 + exp_w + man_w;
    endfunction

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    // Magnitude bits of infinity: exponent all ones, fraction zero, sign clear.
    function automatic fp_word_t fp_inf(input int exp_w, input int man_w);
        return ((fp_word_t'(1) << exp_w) - fp_word_t'(1)) << man_w;
    endfunction

    function automatic fp_word_t fp_qnan(input int exp_w, input int man_w);
        return fp_inf(exp_w, man_w) | (fp_word_t'(1) << (man_w - 1));
    endfunction

    function automatic fp_word_t fp_zero(input logic sign, input int exp_w, input int man_w);
        return fp_word_t'(sign) << (exp_w + man_w);
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; returns W when the input is all zeros.
// Latency: 0 cycles.
// Backpressure: not applicable.
module fp_lzc #(
    parameter int W = 27,
    localparam int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  din,
    output logic [CW-1:0] cnt
);

    logic found;

    always_comb begin
        cnt   = CW'(W);
        found = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (!found && din[i]) begin
                cnt   = CW'(W - 1 - i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_addsub.sv
// Multi-cycle FP add/sub, RNE rounding, flush-to-zero; FPADD_FLAGS_EN adds the {inv,ovf,unf,inx} flags port.
// Latency: output_valid 6 edges after start is accepted, 2 edges for NaN/inf operands.
// Backpressure: result and valid held in DONE until ack_output; start ignored outside IDLE.
module fp_addsub
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [EXP_W+MAN_W:0]   input_a,
    input  logic [EXP_W+MAN_W:0]   input_b,
    input  logic                   op,
    input  logic                   start,
    input  logic                   ack_output,
    output logic [EXP_W+MAN_W:0]   output_z,
    output logic                   output_valid,
    output logic                   idle_status
`ifdef FPADD_FLAGS_EN
    ,
    output logic [3:0]             flags
`endif
);

    localparam int W   = fp_word_w(EXP_W, MAN_W);
    localparam int SW  = MAN_W + 4;
    localparam int LZW = $clog2(SW + 1);
    localparam int EW  = EXP_W + 2;

    localparam fp_word_t INF_F   = fp_inf(EXP_W, MAN_W);
    localparam fp_word_t QNAN_F  = fp_qnan(EXP_W, MAN_W);
    localparam fp_word_t NZERO_F = fp_zero(1'b1, EXP_W, MAN_W);
    localparam logic [W-2:0] INF_MAG  = INF_F[W-2:0];
    localparam logic [W-1:0] QNAN     = QNAN_F[W-1:0];
    localparam logic [W-1:0] NEG_ZERO = NZERO_F[W-1:0];
    localparam logic [EW-1:0] EXP_ALL1 = {2'b00, {EXP_W{1'b1}}};

    fp_state_t state;

    logic [W-1:0]     a_r, b_r;
    logic             op_r;
    logic             sign_big, sign_sml;
    logic [EXP_W-1:0] exp_big, exp_sml;
    logic [SW-1:0]    sig_big, sig_sml;
    logic [SW:0]      sum_r;
    logic [SW-1:0]    norm_r;
    logic [EW-1:0]    exp_n;
    logic             zero_r;
    logic [W-1:0]     z_res;

    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             sa, sb;
    logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_big;
    logic [W-2:0]     mag_a, mag_b;
    logic [SW-1:0]    sig_a, sig_b;
    logic             sp_hit, sp_nan, sp_sign;
    logic [W-1:0]     sp_z;

    always_comb begin
        ea     = a_r[W-2:MAN_W];
        eb     = b_r[W-2:MAN_W];
        fa     = a_r[MAN_W-1:0];
        fb     = b_r[MAN_W-1:0];
        sa     = a_r[W-1];
        sb     = b_r[W-1] ^ op_r;
        a_nan  = (&ea) & (|fa);
        b_nan  = (&eb) & (|fb);
        a_inf  = (&ea) & ~(|fa);
        b_inf  = (&eb) & ~(|fb);
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        // Subnormals have a zero exponent, so they enter the datapath as exact zeros.
        mag_a  = a_zero ? '0 : a_r[W-2:0];
        mag_b  = b_zero ? '0 : b_r[W-2:0];
        sig_a  = a_zero ? '0 : {1'b1, fa, 3'b000};
        sig_b  = b_zero ? '0 : {1'b1, fb, 3'b000};
        a_big  = (mag_a >= mag_b);

        sp_hit  = 1'b0;
        sp_nan  = 1'b0;
        sp_sign = 1'b0;
        if (a_nan || b_nan) begin
            sp_hit = 1'b1;
            sp_nan = 1'b1;
        end else if (a_inf && b_inf) begin
            sp_hit  = 1'b1;
            sp_nan  = (sa != sb);
            sp_sign = sa;
        end else if (a_inf) begin
            sp_hit  = 1'b1;
            sp_sign = sa;
        end else if (b_inf) begin
            sp_hit  = 1'b1;
            sp_sign = sb;
        end
        sp_z = sp_nan ? QNAN : {sp_sign, INF_MAG};
    end

    logic [EXP_W-1:0] diff;
    logic [SW-1:0]    shift_mask, aligned;

    always_comb begin
        diff       = exp_big - exp_sml;
        shift_mask = ~({SW{1'b1}} << diff);
        if (int'(diff) >= MAN_W + 3)
            aligned = {{(SW-1){1'b0}}, |sig_sml};
        else
            aligned = (sig_sml >> diff) | {{(SW-1){1'b0}}, |(sig_sml & shift_mask)};
    end

    logic [LZW-1:0] lz;

    fp_lzc #(.W(SW)) u_lzc (
        .din (sum_r[SW-1:0]),
        .cnt (lz)
    );

    logic [MAN_W:0]   mant;
    logic [MAN_W+1:0] mant_r;
    logic [MAN_W-1:0] frac_f;
    logic [EW-1:0]    exp_f;
    logic             g, r, s, rnd_up, rnd_ovf, rnd_unf;
    logic [W-1:0]     rnd_z;

    always_comb begin
        mant    = norm_r[SW-1:3];
        g       = norm_r[2];
        r       = norm_r[1];
        s       = norm_r[0];
        rnd_up  = g & (r | s | norm_r[3]);
        mant_r  = {1'b0, mant} + {{(MAN_W+1){1'b0}}, rnd_up};
        frac_f  = mant_r[MAN_W+1] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
        exp_f   = exp_n + {{(EW-1){1'b0}}, mant_r[MAN_W+1]};
        // exp_f is two's complement; a set MSB means the exponent went negative.
        rnd_unf = !zero_r && (exp_f[EW-1] || exp_f == '0);
        rnd_ovf = !zero_r && !exp_f[EW-1] && (exp_f >= EXP_ALL1);
        if (zero_r)
            rnd_z = (sign_big & sign_sml) ? NEG_ZERO : '0;
        else if (rnd_unf)
            rnd_z = {sign_big, {(W-1){1'b0}}};
        else if (rnd_ovf)
            rnd_z = {sign_big, INF_MAG};
        else
            rnd_z = {sign_big, exp_f[EXP_W-1:0], frac_f};
    end

`ifdef FPADD_FLAGS_EN
    logic [3:0] flg_res;
    logic [3:0] rnd_flags;

    always_comb begin
        rnd_flags = {1'b0, rnd_ovf, rnd_unf, g | r | s | rnd_ovf | rnd_unf};
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            a_r          <= '0;
            b_r          <= '0;
            op_r         <= 1'b0;
            sign_big     <= 1'b0;
            sign_sml     <= 1'b0;
            exp_big      <= '0;
            exp_sml      <= '0;
            sig_big      <= '0;
            sig_sml      <= '0;
            sum_r        <= '0;
            norm_r       <= '0;
            exp_n        <= '0;
            zero_r       <= 1'b0;
            z_res        <= '0;
            output_z     <= '0;
            output_valid <= 1'b0;
            idle_status  <= 1'b1;
`ifdef FPADD_FLAGS_EN
            flg_res      <= '0;
            flags        <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r         <= input_a;
                        b_r         <= input_b;
                        op_r        <= op;
                        idle_status <= 1'b0;
                        state       <= UNPACK;
                    end
                end
                UNPACK: begin
                    if (sp_hit) begin
                        z_res <= sp_z;
`ifdef FPADD_FLAGS_EN
                        flg_res <= {sp_nan, 3'b000};
`endif
                        state <= DONE;
                    end else begin
                        sign_big <= a_big ? sa : sb;
                        sign_sml <= a_big ? sb : sa;
                        exp_big  <= a_big ? ea : eb;
                        exp_sml  <= a_big ? eb : ea;
                        sig_big  <= a_big ? sig_a : sig_b;
                        sig_sml  <= a_big ? sig_b : sig_a;
                        state    <= ALIGN;
                    end
                end
                ALIGN: begin
                    sig_sml <= aligned;
                    state   <= ADD;
                end
                ADD: begin
                    // Operands are ordered by magnitude, so subtraction never goes negative.
                    if (sign_big ^ sign_sml)
                        sum_r <= {1'b0, sig_big} - {1'b0, sig_sml};
                    else
                        sum_r <= {1'b0, sig_big} + {1'b0, sig_sml};
                    state <= NORM;
                end
                NORM: begin
                    zero_r <= (sum_r == '0);
                    if (sum_r[SW]) begin
                        norm_r <= {sum_r[SW:2], |sum_r[1:0]};
                        exp_n  <= {2'b00, exp_big} + EW'(1);
                    end else begin
                        norm_r <= sum_r[SW-1:0] << lz;
                        exp_n  <= {2'b00, exp_big} - {{(EW-LZW){1'b0}}, lz};
                    end
                    state <= ROUND;
                end
                ROUND: begin
                    z_res <= rnd_z;
`ifdef FPADD_FLAGS_EN
                    flg_res <= rnd_flags;
`endif
                    state <= DONE;
                end
                DONE: begin
                    if (!output_valid) begin
                        output_valid <= 1'b1;
                        output_z     <= z_res;
`ifdef FPADD_FLAGS_EN
                        flags        <= flg_res;
`endif
                    end else if (ack_output) begin
                        output_valid <= 1'b0;
                        idle_status  <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: begin
                    idle_status <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
